// File: rtl/fmdma_pkg.sv
// Shared definitions for the FPGA-RAM DMA burst write sequencer.
package fmdma_pkg;

  localparam int WADDR_W = 8;
  localparam int WDATA_W = 16;

  localparam logic DST_CRAM  = 1'b0;
  localparam logic DST_SFILE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/fmdma_fifo.sv
// Small synchronous word FIFO with registered read data and a flush.
module fmdma_fifo
  import fmdma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [WDATA_W-1:0] wdata,
  output logic [WDATA_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [WDATA_W-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // rdata only moves on a pop so the downstream write data holds between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr];
      end
      count <= count + {{FIFO_AW{1'b0}}, do_push} - {{FIFO_AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fmram_dma.sv
// Burst write sequencer: pulls source words into a FIFO and issues one
// registered CRAM/SFILE write strobe per word, paced by the write slot.
module fmram_dma
  import fmdma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               dst_sel,
  input  logic [WADDR_W-1:0] start_addr,
  input  logic [7:0]         length,
  input  logic [WDATA_W-1:0] src_data,
  input  logic               src_valid,
  output logic               src_rdy,
  input  logic               wr_slot,
  output logic [WDATA_W-1:0] dma_data,
  output logic [WADDR_W-1:0] dma_wraddr,
  output logic               dma_cram_we,
  output logic               dma_sfile_we,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic               dst;
  logic [WADDR_W-1:0] addr;
  logic [8:0]         len9;
  logic [8:0]         fetch_cnt;
  logic [8:0]         write_cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               flush;

  assign src_rdy = (state == ST_RUN) && (fetch_cnt != len9) && !fifo_full;
  assign push    = src_valid && src_rdy;
  assign pop     = (state == ST_RUN) && !fifo_empty && wr_slot && !abort;
  assign flush   = abort && (state != ST_IDLE);

  // The FIFO read register doubles as the write-data output register
  fmdma_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (src_data),
    .rdata (dma_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      dst          <= DST_CRAM;
      addr         <= '0;
      len9         <= '0;
      fetch_cnt    <= '0;
      write_cnt    <= '0;
      dma_wraddr   <= '0;
      dma_cram_we  <= 1'b0;
      dma_sfile_we <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      dma_cram_we  <= 1'b0;
      dma_sfile_we <= 1'b0;
      done         <= 1'b0;

      if (push) fetch_cnt <= fetch_cnt + 9'd1;

      if (pop) begin
        dma_wraddr   <= addr;
        dma_cram_we  <= (dst == DST_CRAM);
        dma_sfile_we <= (dst == DST_SFILE);
        addr         <= addr + 1'b1;
        write_cnt    <= write_cnt + 9'd1;
      end

      // abort wins over start; the final strobe is visible during FINISH
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            dst       <= dst_sel;
            addr      <= start_addr;
            len9      <= (length == 8'd0) ? 9'd256 : {1'b0, length};
            fetch_cnt <= '0;
            write_cnt <= '0;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (pop && ((write_cnt + 9'd1) == len9)) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          done  <= !abort;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmram_dma.sv
// Directed self-checking bench for the DMA burst write sequencer.
module tb_fmram_dma;

  logic        clk = 1'b0;
  logic        rst, start, abort, dst_sel;
  logic [7:0]  start_addr, length;
  logic [15:0] src_data;
  logic        src_valid, src_rdy, wr_slot;
  logic [15:0] dma_data;
  logic [7:0]  dma_wraddr;
  logic        dma_cram_we, dma_sfile_we, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int both_err = 0;
  int slot_err = 0;
  int accepted = 0;
  int start_cyc = 0;
  bit src_en = 1'b0;

  logic [15:0] src_q[$];
  logic [7:0]  log_addr[$];
  logic [15:0] log_data[$];
  logic        log_sf[$];
  int          log_cyc[$];

  fmram_dma #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .dst_sel      (dst_sel),
    .start_addr   (start_addr),
    .length       (length),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_rdy      (src_rdy),
    .wr_slot      (wr_slot),
    .dma_data     (dma_data),
    .dma_wraddr   (dma_wraddr),
    .dma_cram_we  (dma_cram_we),
    .dma_sfile_we (dma_sfile_we),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: present a source word, let the edge pass, sample at the falling edge
  task automatic cycle();
    logic xfer;
    src_valid = src_en && (src_q.size() > 0);
    if (src_valid) src_data = src_q[0];
    else src_data = 16'h0000;
    #1;
    xfer = src_valid && src_rdy;
    @(negedge clk);
    if (xfer) begin
      void'(src_q.pop_front());
      accepted++;
    end
    if (dma_cram_we || dma_sfile_we) begin
      log_addr.push_back(dma_wraddr);
      log_data.push_back(dma_data);
      log_sf.push_back(dma_sfile_we);
      log_cyc.push_back(cyc);
      if (dma_cram_we && dma_sfile_we) both_err++;
      if (!wr_slot) slot_err++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic load_src(input int n, input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i < n; i++) src_q.push_back(base + step * 16'(i));
  endtask

  task automatic start_job(input logic d, input logic [7:0] a, input logic [7:0] l);
    log_addr.delete();
    log_data.delete();
    log_sf.delete();
    log_cyc.delete();
    dst_sel    = d;
    start_addr = a;
    length     = l;
    start      = 1'b1;
    start_cyc  = cyc;
    cycle();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      cycle();
      n++;
    end
    check(tag, done_cnt - d0, 1);
  endtask

  task automatic check_log(input string tag, input int n_exp, input logic [7:0] a0,
                           input logic [15:0] base, input logic [15:0] step, input logic sf);
    int bad;
    logic [7:0] ea;
    logic [15:0] ed;
    bad = 0;
    check({tag, " count"}, log_addr.size(), n_exp);
    for (int i = 0; i < log_addr.size(); i++) begin
      ea = a0 + 8'(i);
      ed = base + step * 16'(i);
      if (log_addr[i] !== ea || log_data[i] !== ed || log_sf[i] !== sf) bad++;
    end
    check({tag, " bad entries"}, bad, 0);
  endtask

  initial begin
    int first;
    int d0;
    int n;

    rst = 1'b1; start = 1'b0; abort = 1'b0; dst_sel = 1'b0;
    start_addr = 8'h00; length = 8'h00; wr_slot = 1'b0;
    src_valid = 1'b0; src_data = 16'h0000;
    cycle();
    cycle();
    check("reset outputs", {dma_data, dma_wraddr, dma_cram_we, dma_sfile_we, src_rdy, busy, done}, 0);
    rst = 1'b0;
    cycle();

    // CRAM job, 3 words streaming with every slot free
    src_en  = 1'b1;
    wr_slot = 1'b1;
    src_q.push_back(16'h1111);
    src_q.push_back(16'h2222);
    src_q.push_back(16'h3333);
    d0 = done_cnt;
    start_job(1'b0, 8'h10, 8'd3);
    check("t1 busy after start", busy, 1);
    wait_done(20, "t1 done seen");
    check("t1 busy after done", busy, 0);
    check_log("t1 cram", 3, 8'h10, 16'h1111, 16'h1111, 1'b0);
    first = (log_cyc.size() > 0) ? log_cyc[0] : -100;
    check("t1 first strobe latency", first - start_cyc, 2);
    first = (log_cyc.size() > 0) ? log_cyc[log_cyc.size() - 1] : -100;
    check("t1 done after last strobe", done_cyc - first, 1);
    cycle();
    cycle();
    check("t1 single done pulse", done_cnt - d0, 1);

    // SFILE job wrapping the address
    load_src(4, 16'hA000, 16'h0001);
    start_job(1'b1, 8'hFE, 8'd4);
    wait_done(30, "t2 done seen");
    check_log("t2 sfile wrap", 4, 8'hFE, 16'hA000, 16'h0001, 1'b1);

    // 256-word job with the write slot free every other cycle
    load_src(256, 16'h4000, 16'h0001);
    slot_err = 0;
    d0 = done_cnt;
    start_job(1'b0, 8'h00, 8'd0);
    n = 0;
    while (done_cnt == d0 && n < 1200) begin
      wr_slot = ~wr_slot;
      cycle();
      n++;
    end
    check("t3 done seen", done_cnt - d0, 1);
    check_log("t3 len256", 256, 8'h00, 16'h4000, 16'h0001, 1'b0);
    check("t3 writes only after slot", slot_err, 0);

    // Slot held off: FIFO fills and backpressures the source
    wr_slot = 1'b0;
    load_src(8, 16'h7000, 16'h0011);
    start_job(1'b0, 8'h60, 8'd8);
    accepted = 0;
    for (int i = 0; i < 10; i++) cycle();
    check("t4 accepted while stalled", accepted, 4);
    check("t4 src_rdy while full", src_rdy, 0);
    check("t4 no strobes while stalled", log_addr.size(), 0);
    wr_slot = 1'b1;
    wait_done(40, "t4 done seen");
    check_log("t4 drain order", 8, 8'h60, 16'h7000, 16'h0011, 1'b0);

    // Abort after two writes, then a clean single-word job
    load_src(8, 16'h5000, 16'h0001);
    d0 = done_cnt;
    start_job(1'b0, 8'h30, 8'd8);
    n = 0;
    while (log_addr.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    check("t5 two writes before abort", log_addr.size(), 2);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("t5 busy after abort", busy, 0);
    check("t5 src_rdy after abort", src_rdy, 0);
    for (int i = 0; i < 5; i++) cycle();
    check("t5 strobes after abort", (log_addr.size() >= 2) && (log_addr.size() <= 3), 1);
    check("t5 no done after abort", done_cnt - d0, 0);
    src_q.delete();
    src_q.push_back(16'hBEEF);
    start_job(1'b0, 8'h40, 8'd1);
    wait_done(20, "t5 restart done seen");
    check_log("t5 restart", 1, 8'h40, 16'hBEEF, 16'h0000, 1'b0);

    // Start while busy is ignored
    load_src(5, 16'h6000, 16'h0003);
    start_job(1'b0, 8'h20, 8'd5);
    cycle();
    cycle();
    dst_sel    = 1'b1;
    start_addr = 8'h99;
    length     = 8'd2;
    start      = 1'b1;
    cycle();
    start      = 1'b0;
    wait_done(30, "t6 done seen");
    check_log("t6 start ignored", 5, 8'h20, 16'h6000, 16'h0003, 1'b0);

    // Reset in the middle of a job
    load_src(6, 16'h6100, 16'h0001);
    start_job(1'b1, 8'h50, 8'd6);
    n = 0;
    while (log_addr.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    check("t6 writes before reset", log_addr.size(), 2);
    rst = 1'b1;
    cycle();
    check("t6 outputs after reset", {dma_data, dma_wraddr, dma_cram_we, dma_sfile_we, src_rdy, busy, done}, 0);
    rst = 1'b0;
    src_q.delete();
    cycle();

    check("no double strobes", both_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
